// File: rtl/datapath_run_monitor.sv
// rtl/datapath_run_monitor.sv - run control, halt/timeout detection, store tally and PC trace for the single-cycle datapath
module datapath_run_monitor #(
    parameter int ADDR_WIDTH        = 16,
    parameter int DATA_WIDTH        = 16,
    parameter int TRACE_DEPTH       = 8,
    parameter int HALT_CYCLES       = 4,
    parameter int TIMEOUT_CYCLES    = 1024,
    parameter int CORE_RESET_CYCLES = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [ADDR_WIDTH-1:0]          pc_in,
    input  logic                           mem_we_in,
    input  logic [ADDR_WIDTH-1:0]          mem_addr_in,
    input  logic [DATA_WIDTH-1:0]          mem_data_in,
    output logic                           core_rst,
    output logic                           running,
    output logic                           done,
    output logic                           timeout,
    output logic [31:0]                    cycle_count,
    output logic [15:0]                    store_count,
    output logic [ADDR_WIDTH-1:0]          last_store_addr,
    output logic [DATA_WIDTH-1:0]          last_store_data,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_rd_idx,
    output logic [ADDR_WIDTH-1:0]          trace_rd_pc,
    output logic [$clog2(TRACE_DEPTH):0]   trace_count
);
    localparam int IDX_W = $clog2(TRACE_DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int HC_W  = $clog2(HALT_CYCLES + 1);
    localparam int RC_W  = $clog2(CORE_RESET_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET_CORE,
        S_RUN,
        S_HALTED,
        S_TIMED_OUT
    } state_t;

    state_t                state_q, state_d;
    logic [RC_W-1:0]       rc_cnt_q, rc_cnt_d;
    logic [31:0]           cycle_q, cycle_d;
    logic [15:0]           store_q, store_d;
    logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
    logic [DATA_WIDTH-1:0] last_data_q, last_data_d;
    logic [IDX_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      tcount_q, tcount_d;
    logic [HC_W-1:0]       stable_q, stable_d;
    logic [ADDR_WIDTH-1:0] prev_pc_q, prev_pc_d;
    logic                  have_prev_q, have_prev_d;
    logic                  core_rst_q, running_q, done_q, timeout_q;
    logic                  trace_we;
    logic                  clear_run;
    logic [ADDR_WIDTH-1:0] trace_q [TRACE_DEPTH];
    logic [IDX_W-1:0]      rd_ptr;

    always_comb begin
        state_d     = state_q;
        rc_cnt_d    = rc_cnt_q;
        cycle_d     = cycle_q;
        store_d     = store_q;
        last_addr_d = last_addr_q;
        last_data_d = last_data_q;
        wr_ptr_d    = wr_ptr_q;
        tcount_d    = tcount_q;
        stable_d    = stable_q;
        prev_pc_d   = prev_pc_q;
        have_prev_d = have_prev_q;
        trace_we    = 1'b0;
        clear_run   = 1'b0;

        case (state_q)
            S_IDLE, S_HALTED, S_TIMED_OUT: begin
                if (start) begin
                    state_d   = S_RESET_CORE;
                    rc_cnt_d  = '0;
                    clear_run = 1'b1;
                end
            end
            S_RESET_CORE: begin
                clear_run = 1'b1;
                if (rc_cnt_q == RC_W'(CORE_RESET_CYCLES - 1)) begin
                    state_d  = S_RUN;
                    rc_cnt_d = '0;
                end else begin
                    rc_cnt_d = rc_cnt_q + RC_W'(1);
                end
            end
            S_RUN: begin
                cycle_d  = cycle_q + 32'd1;
                trace_we = 1'b1;
                wr_ptr_d = wr_ptr_q + IDX_W'(1);
                if (tcount_q != CNT_W'(TRACE_DEPTH))
                    tcount_d = tcount_q + CNT_W'(1);
                if (mem_we_in) begin
                    if (store_q != 16'hFFFF)
                        store_d = store_q + 16'd1;
                    last_addr_d = mem_addr_in;
                    last_data_d = mem_data_in;
                end
                // The first RUN cycle has nothing to compare against, hence have_prev.
                if (have_prev_q && pc_in == prev_pc_q)
                    stable_d = stable_q + HC_W'(1);
                else
                    stable_d = '0;
                prev_pc_d   = pc_in;
                have_prev_d = 1'b1;
                if (stable_d == HC_W'(HALT_CYCLES))
                    state_d = S_HALTED;
                else if (cycle_d == 32'(TIMEOUT_CYCLES))
                    state_d = S_TIMED_OUT;
            end
            default: state_d = S_IDLE;
        endcase

        if (clear_run) begin
            cycle_d     = '0;
            store_d     = '0;
            last_addr_d = '0;
            last_data_d = '0;
            wr_ptr_d    = '0;
            tcount_d    = '0;
            stable_d    = '0;
            have_prev_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rc_cnt_q    <= '0;
            cycle_q     <= '0;
            store_q     <= '0;
            last_addr_q <= '0;
            last_data_q <= '0;
            wr_ptr_q    <= '0;
            tcount_q    <= '0;
            stable_q    <= '0;
            prev_pc_q   <= '0;
            have_prev_q <= 1'b0;
            core_rst_q  <= 1'b1;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rc_cnt_q    <= rc_cnt_d;
            cycle_q     <= cycle_d;
            store_q     <= store_d;
            last_addr_q <= last_addr_d;
            last_data_q <= last_data_d;
            wr_ptr_q    <= wr_ptr_d;
            tcount_q    <= tcount_d;
            stable_q    <= stable_d;
            prev_pc_q   <= prev_pc_d;
            have_prev_q <= have_prev_d;
            core_rst_q  <= (state_d != S_RUN);
            running_q   <= (state_d == S_RESET_CORE) || (state_d == S_RUN);
            done_q      <= (state_d == S_HALTED);
            timeout_q   <= (state_d == S_TIMED_OUT);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TRACE_DEPTH; i++)
                trace_q[i] <= '0;
        end else if (trace_we) begin
            trace_q[wr_ptr_q] <= pc_in;
        end
    end

    // wr_ptr points at the next free slot, so the newest entry is one behind it.
    assign rd_ptr      = wr_ptr_q - IDX_W'(1) - trace_rd_idx;
    assign trace_rd_pc = ({1'b0, trace_rd_idx} >= tcount_q) ? '0 : trace_q[rd_ptr];

    assign core_rst        = core_rst_q;
    assign running         = running_q;
    assign done            = done_q;
    assign timeout         = timeout_q;
    assign cycle_count     = cycle_q;
    assign store_count     = store_q;
    assign last_store_addr = last_addr_q;
    assign last_store_data = last_data_q;
    assign trace_count     = tcount_q;
endmodule

// File: tb/tb_datapath_run_monitor.sv
// tb/tb_datapath_run_monitor.sv - scoreboard bench for datapath_run_monitor with directed PC programs
module tb_datapath_run_monitor;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] pc_in;
    logic        mem_we_in;
    logic [15:0] mem_addr_in;
    logic [15:0] mem_data_in;
    logic        core_rst, running, done, timeout;
    logic [31:0] cycle_count;
    logic [15:0] store_count, last_store_addr, last_store_data;
    logic [2:0]  trace_rd_idx;
    logic [15:0] trace_rd_pc;
    logic [3:0]  trace_count;

    datapath_run_monitor #(
        .ADDR_WIDTH(16), .DATA_WIDTH(16), .TRACE_DEPTH(8),
        .HALT_CYCLES(4), .TIMEOUT_CYCLES(32), .CORE_RESET_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pc_in(pc_in),
        .mem_we_in(mem_we_in), .mem_addr_in(mem_addr_in), .mem_data_in(mem_data_in),
        .core_rst(core_rst), .running(running), .done(done), .timeout(timeout),
        .cycle_count(cycle_count), .store_count(store_count),
        .last_store_addr(last_store_addr), .last_store_data(last_store_data),
        .trace_rd_idx(trace_rd_idx), .trace_rd_pc(trace_rd_pc), .trace_count(trace_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        done;
        logic        tmo;
        logic [31:0] cyc;
        logic [15:0] st;
        logic [15:0] la;
        logic [15:0] ld;
        logic [3:0]  tc;
        logic [2:0]  ti [3];
        logic [15:0] tp [3];
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic d, input logic t, input int cyc, input int st,
                                input int la, input int ld, input int tc,
                                input int i0, input int p0, input int i1, input int p1,
                                input int i2, input int p2);
        exp_t e;
        e.done = d; e.tmo = t; e.cyc = 32'(cyc); e.st = 16'(st);
        e.la = 16'(la); e.ld = 16'(ld); e.tc = 4'(tc);
        e.ti[0] = 3'(i0); e.tp[0] = 16'(p0);
        e.ti[1] = 3'(i1); e.tp[1] = 16'(p1);
        e.ti[2] = 3'(i2); e.tp[2] = 16'(p2);
        return e;
    endfunction

    // PC presented on RUN cycle k (0-based) for each directed program.
    function automatic logic [15:0] pc_for(input int mode, input int k);
        case (mode)
            0:       return 16'((k < 3) ? k : 3);
            1:       return 16'((k < 2) ? k : 2);
            2:       return 16'(k);
            default: return 16'((k < 27) ? k : 27);
        endcase
    endfunction

    // Monitor: each rising edge of done|timeout consumes one expected result.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if ((done || timeout) && !prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_completion actual=%0d required=0", exp_q.size() + 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("done", 32'(done), 32'(e.done));
                    chk("timeout", 32'(timeout), 32'(e.tmo));
                    chk("core_rst_after_end", 32'(core_rst), 32'd1);
                    chk("running_after_end", 32'(running), 32'd0);
                    chk("cycle_count", cycle_count, e.cyc);
                    chk("store_count", 32'(store_count), 32'(e.st));
                    chk("last_store_addr", 32'(last_store_addr), 32'(e.la));
                    chk("last_store_data", 32'(last_store_data), 32'(e.ld));
                    chk("trace_count", 32'(trace_count), 32'(e.tc));
                    for (int i = 0; i < 3; i++) begin
                        trace_rd_idx = e.ti[i];
                        #1;
                        chk($sformatf("trace_idx%0d", e.ti[i]), 32'(trace_rd_pc), 32'(e.tp[i]));
                    end
                end
            end
            prev = done || timeout;
        end
    end

    task automatic pulse_start_and_wait_run();
        int n;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (core_rst && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_run", 32'(core_rst), 32'd0);
        chk("reset_core_cycles", 32'(n), 32'd2);
        chk("run_start_running", 32'(running), 32'd1);
        chk("run_start_cycle_count", cycle_count, 32'd0);
        chk("run_start_trace_count", 32'(trace_count), 32'd0);
        chk("run_start_store_count", 32'(store_count), 32'd0);
    endtask

    task automatic run_prog(input int mode, input exp_t e);
        int k;
        exp_q.push_back(e);
        pulse_start_and_wait_run();
        k = 0;
        while (!(done || timeout) && k < 100) begin
            pc_in = pc_for(mode, k);
            if (mode == 1 && k == 0) begin
                mem_we_in = 1'b1; mem_addr_in = 16'h0010; mem_data_in = 16'hBEEF;
            end else if (mode == 1 && k == 1) begin
                mem_we_in = 1'b1; mem_addr_in = 16'h0011; mem_data_in = 16'h1234;
            end else begin
                mem_we_in = 1'b0; mem_addr_in = 16'h0055; mem_data_in = 16'hDEAD;
            end
            start = (mode == 2 && k == 5);
            @(posedge clk); #1;
            k++;
        end
        start     = 1'b0;
        mem_we_in = 1'b0;
        if (k >= 100)
            chk("run_completion_bound", 32'(k), 32'd99);
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pc_in = '0; mem_we_in = 1'b0;
        mem_addr_in = '0; mem_data_in = '0; trace_rd_idx = '0;
        #3 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("idle_core_rst", 32'(core_rst), 32'd1);
        chk("idle_running", 32'(running), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_timeout", 32'(timeout), 32'd0);
        chk("idle_cycle_count", cycle_count, 32'd0);
        chk("idle_trace_count", 32'(trace_count), 32'd0);
        chk("idle_trace_rd_pc", 32'(trace_rd_pc), 32'd0);

        run_prog(0, mk(1, 0, 8, 0, 0, 0, 8,          0, 3,  4, 3,  5, 2));
        run_prog(1, mk(1, 0, 7, 2, 16'h0011, 16'h1234, 7, 0, 2,  5, 1,  7, 0));
        run_prog(2, mk(0, 1, 32, 0, 0, 0, 8,         0, 31, 3, 28, 7, 24));
        run_prog(3, mk(1, 0, 32, 0, 0, 0, 8,         0, 27, 4, 27, 5, 26));

        pulse_start_and_wait_run();
        for (int k = 0; k < 5; k++) begin
            pc_in = 16'(k + 100);
            mem_we_in = (k == 2);
            mem_addr_in = 16'h0042; mem_data_in = 16'hA5A5;
            @(posedge clk); #1;
        end
        mem_we_in = 1'b0;
        chk("midrun_cycle_count", cycle_count, 32'd5);
        rst = 1'b1;
        #1;
        chk("abort_core_rst", 32'(core_rst), 32'd1);
        chk("abort_running", 32'(running), 32'd0);
        chk("abort_cycle_count", cycle_count, 32'd0);
        chk("abort_store_count", 32'(store_count), 32'd0);
        chk("abort_last_store_addr", 32'(last_store_addr), 32'd0);
        chk("abort_trace_count", 32'(trace_count), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("post_abort_core_rst", 32'(core_rst), 32'd1);
        chk("post_abort_running", 32'(running), 32'd0);
        chk("post_abort_done", 32'(done), 32'd0);
        chk("post_abort_cycle_count", cycle_count, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/datapath_run_monitor.md
Name: datapath_run_monitor

Overview:
- Parametrised run-control and observation block for the single-cycle datapath, instantiated beside the datapath, instruction memory, data memory and control unit in bench and FPGA builds.
- Sequences the core reset, counts executed cycles and detects program halt (PC stable) or timeout.
- Tallies data-memory stores and keeps a circular trace of the most recent PCs, readable through an indexed port.

Parameters:
ADDR_WIDTH, 16, width of PC and data-memory address
DATA_WIDTH, 16, width of instruction word and store data
TRACE_DEPTH, 8, number of PC trace entries; power of two, >= 2
HALT_CYCLES, 4, consecutive cycles of unchanged PC that declare halt; >= 1
TIMEOUT_CYCLES, 1024, RUN cycles before timeout; >= HALT_CYCLES + 1
CORE_RESET_CYCLES, 2, cycles core_rst is held after start; >= 1

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  single-cycle pulse; begins a run from IDLE, HALTED or TIMED_OUT
pc_in  input  ADDR_WIDTH  current datapath PC (instruction memory address_1)
mem_we_in  input  1  data-memory write enable from control unit
mem_addr_in  input  ADDR_WIDTH  data-memory address
mem_data_in  input  DATA_WIDTH  data-memory write data
core_rst  output  1  reset to datapath (active-high)
running  output  1  high in RESET_CORE and RUN
done  output  1  high in HALTED
timeout  output  1  high in TIMED_OUT
cycle_count  output  32  RUN cycles elapsed in current/last run
store_count  output  16  stores observed in current/last run, saturating
last_store_addr  output  ADDR_WIDTH  address of most recent store
last_store_data  output  DATA_WIDTH  data of most recent store
trace_rd_idx  input  clog2(TRACE_DEPTH)  0 = newest entry, k = k-th older
trace_rd_pc  output  ADDR_WIDTH  combinational read of selected trace entry
trace_count  output  clog2(TRACE_DEPTH)+1  valid trace entries, saturates at TRACE_DEPTH

Behaviour:
- Reset (async, rst=1): state IDLE; core_rst=1; running=done=timeout=0; cycle_count, store_count, trace_count, last_store_addr, last_store_data, trace write pointer, stable counter all 0; trace entries 0.
- States: IDLE, RESET_CORE, RUN, HALTED, TIMED_OUT.
- IDLE: core_rst=1. start -> RESET_CORE.
- RESET_CORE: core_rst=1; clears cycle_count, store_count, trace_count, stable counter, last_store_*; counts CORE_RESET_CYCLES cycles, then -> RUN.
- RUN: core_rst=0. Each cycle:
  - cycle_count += 1.
  - pc_in written to trace[wr_ptr]; wr_ptr wraps modulo TRACE_DEPTH; trace_count += 1 saturating.
  - If mem_we_in=1: store_count += 1 saturating at 0xFFFF; last_store_addr/data captured.
- Halt detection in RUN:
  - Stable counter increments when pc_in equals the PC registered the previous RUN cycle, else clears to 0.
  - The first RUN cycle has no previous PC and never counts as stable.
  - When the stable counter reaches HALT_CYCLES -> HALTED (one-cycle registered decision).
- Timeout: cycle_count reaching TIMEOUT_CYCLES -> TIMED_OUT. If halt and timeout qualify in the same cycle, HALTED wins.
- HALTED / TIMED_OUT:
  - core_rst=1, freezing the core.
  - Counters, trace and last_store_* hold for readout; no further sampling.
  - start -> RESET_CORE (rerun).
- start while running=1 is ignored.
- trace_rd_pc = trace[(wr_ptr - 1 - trace_rd_idx) mod TRACE_DEPTH].
- If trace_rd_idx >= trace_count, trace_rd_pc is 0.
- rst mid-run aborts immediately to IDLE with all reset values; the core is held in reset.
- All outputs except trace_rd_pc are registered.

Test Plan:
- Reset then idle: rst=1 100ps, release, no start for 10 cycles -> core_rst=1, running=0, done=0, cycle_count=0, trace_count=0.
- Linear program with halt: start; PC 0,1,2,3 then holds at 3 -> running for 2 reset cycles, then RUN; done=1 after the 4th repeated PC; cycle_count=8; trace idx0=3, idx4=3, idx5=2; core_rst=1 after done.
- Stores: run with mem_we_in pulsed at (addr 0x0010, data 0xBEEF) then (0x0011, 0x1234) -> store_count=2, last_store_addr=0x0011, last_store_data=0x1234 at halt.
- Timeout: TIMEOUT_CYCLES=32, PC increments every cycle -> timeout=1 with cycle_count=32, done=0; trace idx0=31, trace_count=8, wrap correct.
- Simultaneous halt/timeout: TIMEOUT_CYCLES chosen so the stable counter hits HALT_CYCLES in the same cycle -> done=1, timeout=0.
- Reset mid-run and rerun: assert rst during RUN -> IDLE, counters 0. Then start after a HALTED run -> RESET_CORE clears counters, trace_count restarts from 0.
